// File: rtl/minterm_sweep_checker.sv
// Exhaustive sweep checker: walks every minterm index, compares an external
// combinational function against a golden sum-of-minterms mask, and tallies results.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SWEEP | driving sweep_idx 0..2^N-1, one compare per clock
// DONE  | sweep finished, results held until next start
module minterm_sweep_checker #(
  parameter int                      N_VARS = 4,
  parameter logic [(1<<N_VARS)-1:0]  MASK   = 16'hDF03
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mask_load,
  input  logic [(1<<N_VARS)-1:0]   mask_in,
  input  logic                     dut_f,
  output logic [N_VARS-1:0]        sweep_idx,
  output logic                     sweep_valid,
  output logic                     gold_f,
  output logic                     busy,
  output logic                     done,
  output logic [N_VARS:0]          ones_count,
  output logic [N_VARS:0]          err_count,
  output logic                     err_flag,
  output logic [N_VARS-1:0]        first_err_idx
);

  localparam int                NM       = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_IDX = N_VARS'(NM - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state_q;
  logic [NM-1:0]       mask_q;
  logic [N_VARS-1:0]   sweep_idx_q;
  logic                sweep_valid_q;
  logic                busy_q;
  logic                done_q;
  logic [N_VARS:0]     ones_q;
  logic [N_VARS:0]     err_q;
  logic                err_flag_q;
  logic [N_VARS-1:0]   first_err_q;
  logic                mismatch;

  assign gold_f   = mask_q[sweep_idx_q];
  assign mismatch = dut_f ^ gold_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mask_q        <= MASK;
      sweep_idx_q   <= '0;
      sweep_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ones_q        <= '0;
      err_q         <= '0;
      err_flag_q    <= 1'b0;
      first_err_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A same-cycle load and start both land, so the sweep sees the new mask.
          if (mask_load) mask_q <= mask_in;
          if (start) begin
            state_q       <= SWEEP;
            sweep_idx_q   <= '0;
            sweep_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            ones_q        <= '0;
            err_q         <= '0;
            err_flag_q    <= 1'b0;
            first_err_q   <= '0;
          end
        end
        SWEEP: begin
          ones_q <= ones_q + {{N_VARS{1'b0}}, gold_f};
          err_q  <= err_q + {{N_VARS{1'b0}}, mismatch};
          if (mismatch && !err_flag_q) begin
            err_flag_q  <= 1'b1;
            first_err_q <= sweep_idx_q;
          end
          if (sweep_idx_q == LAST_IDX) begin
            state_q       <= DONE;
            sweep_idx_q   <= '0;
            sweep_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            sweep_idx_q <= sweep_idx_q + N_VARS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sweep_idx     = sweep_idx_q;
  assign sweep_valid   = sweep_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ones_count    = ones_q;
  assign err_count     = err_q;
  assign err_flag      = err_flag_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: a 4-input and a 3-input instance checked each
// cycle against a sweep-level model built from popcounts over the active mask.
module tb_minterm_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [2];
  logic        load_a  [2];
  logic [15:0] min_a   [2];
  logic [15:0] tab_a   [2];

  logic [3:0] idx4, first4;
  logic [4:0] ones4, err4;
  logic       valid4, gold4, busy4, done4, flag4, f4;
  logic [2:0] idx3, first3;
  logic [3:0] ones3, err3;
  logic       valid3, gold3, busy3, done3, flag3, f3;

  assign f4 = tab_a[0][idx4];
  assign f3 = tab_a[1][{1'b0, idx3}];

  minterm_sweep_checker u4 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mask_load(load_a[0]),
    .mask_in(min_a[0]), .dut_f(f4), .sweep_idx(idx4), .sweep_valid(valid4),
    .gold_f(gold4), .busy(busy4), .done(done4), .ones_count(ones4),
    .err_count(err4), .err_flag(flag4), .first_err_idx(first4)
  );

  minterm_sweep_checker #(.N_VARS(3), .MASK(8'h96)) u3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mask_load(load_a[1]),
    .mask_in(min_a[1][7:0]), .dut_f(f3), .sweep_idx(idx3), .sweep_valid(valid3),
    .gold_f(gold3), .busy(busy3), .done(done3), .ones_count(ones3),
    .err_count(err3), .err_flag(flag3), .first_err_idx(first3)
  );

  // Sweep-level model: which mask/diff the current sweep uses and how far it got.
  bit          m_run  [2] = '{1'b0, 1'b0};
  bit          m_done [2] = '{1'b0, 1'b0};
  int          m_pos  [2] = '{0, 0};
  logic [15:0] m_mask [2] = '{16'hDF03, 16'h0096};
  logic [15:0] m_smask[2] = '{16'h0, 16'h0};
  logic [15:0] m_sdiff[2] = '{16'h0, 16'h0};

  function automatic int nm(int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic logic [15:0] nmask(int i);
    return (i == 0) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic int popc(logic [15:0] v);
    int c = 0;
    for (int j = 0; j < 16; j++) c += int'(v[j]);
    return c;
  endfunction

  function automatic logic [15:0] lowk(int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[15:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_pos[i] = 0;
        m_smask[i] = 16'h0; m_sdiff[i] = 16'h0;
      end
      m_mask[0] = 16'hDF03;
      m_mask[1] = 16'h0096;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_run[i]) begin
          m_pos[i]++;
          if (m_pos[i] == nm(i)) begin
            m_run[i] = 1'b0; m_done[i] = 1'b1; m_pos[i] = 0;
          end
        end else begin
          if (load_a[i]) m_mask[i] = min_a[i] & nmask(i);
          if (start_a[i]) begin
            m_run[i] = 1'b1; m_done[i] = 1'b0; m_pos[i] = 0;
            m_smask[i] = m_mask[i];
            m_sdiff[i] = (m_mask[i] ^ tab_a[i]) & nmask(i);
          end
        end
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int vcnt[2] = '{0, 0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int i);
    logic [31:0] a_idx, a_valid, a_gold, a_busy, a_done, a_ones, a_err, a_flag, a_first;
    int k, e_idx, e_ones, e_err, e_first;
    bit found;
    if (i == 0) begin
      a_idx = 32'(idx4); a_valid = 32'(valid4); a_gold = 32'(gold4); a_busy = 32'(busy4);
      a_done = 32'(done4); a_ones = 32'(ones4); a_err = 32'(err4); a_flag = 32'(flag4);
      a_first = 32'(first4);
    end else begin
      a_idx = 32'(idx3); a_valid = 32'(valid3); a_gold = 32'(gold3); a_busy = 32'(busy3);
      a_done = 32'(done3); a_ones = 32'(ones3); a_err = 32'(err3); a_flag = 32'(flag3);
      a_first = 32'(first3);
    end
    k      = m_run[i] ? m_pos[i] : (m_done[i] ? nm(i) : 0);
    e_idx  = m_run[i] ? m_pos[i] : 0;
    e_ones = popc(m_smask[i] & lowk(k));
    e_err  = popc(m_sdiff[i] & lowk(k));
    e_first = 0;
    found = 1'b0;
    for (int j = 0; j < k; j++)
      if (!found && m_sdiff[i][j]) begin e_first = j; found = 1'b1; end
    chk($sformatf("u%0d.sweep_idx", i), a_idx, 32'(e_idx));
    chk($sformatf("u%0d.sweep_valid", i), a_valid, 32'(m_run[i]));
    chk($sformatf("u%0d.busy", i), a_busy, 32'(m_run[i]));
    chk($sformatf("u%0d.done", i), a_done, 32'(m_done[i]));
    chk($sformatf("u%0d.gold_f", i), a_gold, 32'(m_mask[i][e_idx]));
    chk($sformatf("u%0d.ones_count", i), a_ones, 32'(e_ones));
    chk($sformatf("u%0d.err_count", i), a_err, 32'(e_err));
    chk($sformatf("u%0d.err_flag", i), a_flag, 32'(e_err != 0));
    chk($sformatf("u%0d.first_err_idx", i), a_first, 32'(e_first));
  endtask

  // Every cycle: compare at the falling edge, then move to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cmp(0);
    cmp(1);
    if (valid4) vcnt[0]++;
    if (valid3) vcnt[1]++;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(int i, bit ld, logic [15:0] m);
    start_a[i] = 1'b1; load_a[i] = ld; min_a[i] = m;
    tick();
    start_a[i] = 1'b0; load_a[i] = 1'b0;
  endtask

  task automatic wait_done(int i);
    for (int c = 0; c < 40 && !((i == 0) ? done4 : done3); c++) tick();
    chk($sformatf("u%0d.done_wait", i), 32'((i == 0) ? done4 : done3), 32'd1);
  endtask

  // Correct function under test: m(0,1,8,9,10,11,12,14,15) as a sum of products.
  function automatic logic [15:0] ref4();
    logic [15:0] t;
    logic [3:0]  v;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      t[k] = (!v[3] && !v[2] && !v[1]) || (v[3] && !v[2]) ||
             (v[3] && v[2] && !v[0]) || (v[3] && v[2] && v[1]);
    end
    return t;
  endfunction

  function automatic logic [15:0] ref3();
    logic [15:0] t = 16'h0;
    logic [2:0]  v;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      t[k] = v[2] ^ v[1] ^ v[0];
    end
    return t;
  endfunction

  initial begin
    int base;
    logic [15:0] m, flips;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0; load_a[i] = 1'b0; min_a[i] = 16'h0; tab_a[i] = 16'h0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset.idx", 32'(idx4), 32'd0);
    chk("reset.valid", 32'(valid4), 32'd0);
    chk("reset.gold4", 32'(gold4), 32'd1);
    chk("reset.gold3", 32'(gold3), 32'd0);

    // Correct function, default mask.
    tab_a[0] = ref4();
    base = vcnt[0];
    pulse_start(0, 1'b0, 16'h0);
    wait_done(0);
    chk("t1.valid_cycles", 32'(vcnt[0] - base), 32'd16);
    chk("t1.ones", 32'(ones4), 32'd9);
    chk("t1.err", 32'(err4), 32'd0);
    chk("t1.flag", 32'(flag4), 32'd0);

    // Function wrong at indices 10 and 13.
    tab_a[0] = ref4() ^ 16'h2400;
    pulse_start(0, 1'b0, 16'h0);
    wait_done(0);
    chk("t2.err", 32'(err4), 32'd2);
    chk("t2.flag", 32'(flag4), 32'd1);
    chk("t2.first", 32'(first4), 32'd10);
    chk("t2.ones", 32'(ones4), 32'd9);

    // Load together with start: all-ones then all-zeros mask, dut_f = 1.
    tab_a[0] = 16'hFFFF;
    pulse_start(0, 1'b1, 16'hFFFF);
    wait_done(0);
    chk("t3.ones", 32'(ones4), 32'd16);
    chk("t3.err", 32'(err4), 32'd0);
    pulse_start(0, 1'b1, 16'h0000);
    wait_done(0);
    chk("t3.err16", 32'(err4), 32'd16);
    chk("t3.first", 32'(first4), 32'd0);

    // Load alone in DONE, then start/load mid-sweep must be ignored.
    load_a[0] = 1'b1; min_a[0] = 16'hDF03;
    tick();
    load_a[0] = 1'b0;
    chk("t4.hold_err", 32'(err4), 32'd16);
    tab_a[0] = ref4();
    pulse_start(0, 1'b0, 16'h0);
    repeat (5) tick();
    chk("t4.at_idx5", 32'(idx4), 32'd5);
    pulse_start(0, 1'b1, 16'h0000);
    wait_done(0);
    chk("t4.ones", 32'(ones4), 32'd9);
    chk("t4.err", 32'(err4), 32'd0);

    // Async reset mid-sweep with a different mask loaded.
    pulse_start(0, 1'b1, 16'h1234);
    repeat (7) tick();
    chk("t5.at_idx7", 32'(idx4), 32'd7);
    #1 rst = 1'b1;
    #1;
    chk("t5.rst_idx", 32'(idx4), 32'd0);
    chk("t5.rst_valid", 32'(valid4), 32'd0);
    chk("t5.rst_busy", 32'(busy4), 32'd0);
    chk("t5.rst_done", 32'(done4), 32'd0);
    chk("t5.rst_ones", 32'(ones4), 32'd0);
    chk("t5.rst_err", 32'(err4), 32'd0);
    chk("t5.rst_flag", 32'(flag4), 32'd0);
    chk("t5.rst_first", 32'(first4), 32'd0);
    chk("t5.rst_gold", 32'(gold4), 32'd1);
    #1 rst = 1'b0;
    tick();
    pulse_start(0, 1'b0, 16'h0);
    wait_done(0);
    chk("t5.mask_restored_ones", 32'(ones4), 32'd9);
    chk("t5.mask_restored_err", 32'(err4), 32'd0);

    // Three-input instance, then back-to-back restart from DONE.
    tab_a[1] = ref3();
    base = vcnt[1];
    pulse_start(1, 1'b0, 16'h0);
    wait_done(1);
    chk("t6.valid_cycles", 32'(vcnt[1] - base), 32'd8);
    chk("t6.ones", 32'(ones3), 32'd4);
    chk("t6.err", 32'(err3), 32'd0);
    pulse_start(1, 1'b0, 16'h0);
    chk("t6.b2b_idx", 32'(idx3), 32'd0);
    chk("t6.b2b_valid", 32'(valid3), 32'd1);
    chk("t6.b2b_done", 32'(done3), 32'd0);
    wait_done(1);

    // Randomized masks, error patterns and ignored mid-sweep traffic.
    for (int r = 0; r < 12; r++) begin
      int i;
      i = r % 2;
      m     = 16'($urandom) & nmask(i);
      flips = 16'($urandom & $urandom & $urandom) & nmask(i);
      tab_a[i] = m ^ flips;
      if ($urandom_range(0, 1) == 1) begin
        pulse_start(i, 1'b1, m);
      end else begin
        load_a[i] = 1'b1; min_a[i] = m;
        tick();
        load_a[i] = 1'b0;
        pulse_start(i, 1'b0, 16'($urandom));
      end
      for (int c = 0; c < nm(i) / 2; c++) begin
        start_a[i] = 1'($urandom); load_a[i] = 1'($urandom); min_a[i] = 16'($urandom);
        tick();
      end
      start_a[i] = 1'b0; load_a[i] = 1'b0;
      wait_done(i);
      chk($sformatf("rand%0d.ones", r), 32'((i == 0) ? 32'(ones4) : 32'(ones3)), 32'(popc(m)));
      chk($sformatf("rand%0d.err", r), 32'((i == 0) ? 32'(err4) : 32'(err3)), 32'(popc(flips)));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/minterm_sweep_checker.md
# minterm_sweep_checker

Parametrised, self-checking exhaustive sweep engine for N-input Boolean functions given as a sum-of-minterms mask. On `start` it walks every input combination from 0 to 2^N-1, one per clock. At each step it drives the combination to an external function under test and compares that unit's output against the golden mask bit. It counts golden ones and mismatches, and records the first failing minterm. It sits beside the combinational function models (dataflow/gate/behavioural) as their reusable, synthesizable checker, replacing hand-written per-function stimulus loops.

## Interface
- `N_VARS`, default 4: number of function inputs (1..8). W is the MSB of the index and Z the LSB.
- `MASK`, default 16'hDF03: reset-time golden mask, width 2^N_VARS. Bit k=1 means minterm k is in F. The default encodes m(0,1,8,9,10,11,12,14,15).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a sweep; honoured only in IDLE or DONE.
- `mask_load`, input, 1: loads `mask_in` into the golden mask register; honoured only in IDLE or DONE.
- `mask_in`, input, 2^N_VARS: new golden mask.
- `dut_f`, input, 1: output of the external function under test, evaluated combinationally on `sweep_idx`.
- `sweep_idx`, output, N_VARS: current input combination driven to the function under test.
- `sweep_valid`, output, 1: high while `sweep_idx`, `gold_f` and `dut_f` form a valid compare.
- `gold_f`, output, 1: the golden bit, mask_reg[sweep_idx] (combinational from registers).
- `busy`, output, 1: high in SWEEP.
- `done`, output, 1: high in DONE; held until the next accepted `start` or reset.
- `ones_count`, output, N_VARS+1: number of golden ones seen in the last or current sweep.
- `err_count`, output, N_VARS+1: number of mismatches (dut_f != gold_f).
- `err_flag`, output, 1: set on the first mismatch of a sweep.
- `first_err_idx`, output, N_VARS: index of the first mismatch; 0 if none.

## Operation
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on `start`.
  - SWEEP -> DONE after index 2^N-1 is checked.
  - DONE -> SWEEP on `start`.
  - No path back to IDLE except reset.
- Reset values:
  - State IDLE; mask_reg = MASK.
  - `sweep_idx`=0, `sweep_valid`=0, `busy`=0, `done`=0.
  - `ones_count`=0, `err_count`=0, `err_flag`=0, `first_err_idx`=0.
  - `gold_f` = MASK[0].
- Accepted `start`:
  - Clears `ones_count`, `err_count`, `err_flag`, `first_err_idx` and `done`.
  - Sets `sweep_idx`=0 and enters SWEEP.
- In SWEEP, each cycle with `sweep_valid`=1, the following happen at the clock edge:
  - `ones_count` += gold_f.
  - `err_count` += (dut_f != gold_f).
  - On a mismatch with `err_flag`=0: `first_err_idx` <= sweep_idx and `err_flag` <= 1.
  - `sweep_idx` increments by 1. At 2^N-1 it wraps to 0 and the state moves to DONE.
- Counter widths:
  - Counters are N_VARS+1 bits, so the maximum value 2^N fits without wrap (e.g. 16 = 5'b10000 for N=4).
  - Counters never saturate or overflow by construction.
- `start` and `mask_load` are ignored while in SWEEP. The mask is stable for the whole sweep.
- `mask_load` and `start` in the same cycle (IDLE/DONE): both take effect on that edge, and the sweep uses the new mask.
- `mask_load` alone leaves the counters and `done` unchanged.
- `gold_f` is valid whenever `sweep_valid`=1. Outside SWEEP it reflects mask_reg[sweep_idx] and carries no meaning.

## Timing
- Start latency: `start` is sampled at edge E0. `busy`=1, `sweep_valid`=1 and `sweep_idx`=0 appear after E0.
- Sweep length: exactly 2^N_VARS cycles with `sweep_valid`=1, indices 0,1,...,2^N-1 in order.
- The last compare (index 2^N-1) is accumulated at edge E0+2^N. At that same edge:
  - `busy` and `sweep_valid` drop to 0.
  - `done` rises to 1.
  - Counters hold their final values.
- Combinational path: `dut_f` must settle within the same cycle as the `sweep_idx` that drives it. There is no DUT pipeline latency.
- Reset mid-sweep: `rst` forces all reset values immediately, without waiting for `clk`. Sweep progress and any loaded mask are lost; mask_reg returns to MASK.
- Back-to-back: `start` sampled while `done`=1 begins a new sweep on the next cycle. There are no idle cycles in between.

## Test plan
- Default MASK, with `dut_f` tied to a correct model of m(0,1,8,9,10,11,12,14,15):
  - Exactly 16 valid cycles with indices 0..15.
  - At the end: `ones_count`=9, `err_count`=0, `err_flag`=0, `done`=1.
- Same setup with `dut_f` inverted only at indices 10 and 13:
  - `err_count`=2, `err_flag`=1, `first_err_idx`=10, `ones_count`=9.
- `mask_load` with `mask_in`=16'hFFFF plus `start` in the same cycle, `dut_f`=1:
  - `ones_count`=16 (5'b10000), `err_count`=0.
  - Then `mask_load` 16'h0000 with `dut_f`=1 gives `err_count`=16 and `first_err_idx`=0.
- Assert `start` and `mask_load`=16'h0000 at index 5 of a sweep (both must be ignored):
  - The sweep completes with the original mask; `ones_count`=9.
  - Then assert `rst` at index 7 of a new sweep: all outputs reach their reset values before the next edge, and mask_reg = 16'hDF03.
- N_VARS=3 with MASK=8'h96 and a correct `dut_f`:
  - 8 valid cycles, `ones_count`=4, `err_count`=0.
  - A second `start` issued while `done`=1 restarts at index 0 on the next cycle.
